// File: rtl/decoder_sched_pkg.sv
// Shared constants, FSM state type and the round-robin search helper for decoder_rr_scheduler.
package decoder_sched_pkg;

    localparam int unsigned N_REQ  = 16;
    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request bit scanning ptr, ptr+1, ... with modulo-N_REQ wrap.
    function automatic rr_pick_t next_rr_idx(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
        rr_pick_t         pick;
        logic [IDX_W-1:0] cand;
        pick = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!pick.found && req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/decoder_rr_scheduler_if.sv
// Requester-side bundle of decoder_rr_scheduler: request/release in, grant status out.
interface decoder_rr_scheduler_if;
    import decoder_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_onehot;
    logic             timeout;

    modport master (
        output req, done,
        input  gnt_valid, gnt_idx, gnt_onehot, timeout
    );

    modport slave (
        input  req, done,
        output gnt_valid, gnt_idx, gnt_onehot, timeout
    );
endinterface

// File: rtl/decoder_4_16.sv
// 4-to-16 one-hot decoder with enable; purely combinational, clk only feeds the sanity check.
module decoder_4_16 (
    input  logic        clk,
    input  logic [3:0]  in,
    input  logic        enable,
    output logic [15:0] out
);

    assign out = enable ? (16'(1) << in) : 16'h0000;

    a_onehot0 : assert property (@(posedge clk) $onehot0(out));

endmodule

// File: rtl/decoder_rr_scheduler.sv
// Round-robin owner selection for a 16-way select, decoded through decoder_4_16.
// Build option: HOLD_TIMEOUT_EN adds the MAX_HOLD forced release and the timeout pulse.
module decoder_rr_scheduler
    import decoder_sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    decoder_rr_scheduler_if.slave bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("decoder_rr_scheduler: MAX_HOLD must be in 2..255");
    end

    state_t           state, state_nxt;
    logic [IDX_W-1:0] gnt_idx, idx_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic             gnt_valid;
    logic [N_REQ-1:0] onehot;
    rr_pick_t         pick_c;
    logic             owner_drop_c;
    logic             release_c;
`ifdef HOLD_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              hold_lim_c;
    logic              timeout, timeout_nxt;
`endif

    // State and grant registers; reset drops any grant without release side effects.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= (state_nxt == GRANT);
            ptr       <= ptr_nxt;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt  <= hold_nxt;
            timeout   <= timeout_nxt;
`endif
        end
    end

    // Next-state: pick in IDLE, release on done / owner drop / hold limit in GRANT.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = gnt_idx;
        ptr_nxt      = ptr;
        pick_c       = next_rr_idx(bus.req, ptr);
        owner_drop_c = !bus.req[gnt_idx];
        release_c    = 1'b0;
`ifdef HOLD_TIMEOUT_EN
        hold_nxt     = hold_cnt;
        timeout_nxt  = 1'b0;
        hold_lim_c   = (hold_cnt == HOLD_LAST);
`endif
        case (state)
            IDLE: begin
                if (pick_c.found) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick_c.idx;
`ifdef HOLD_TIMEOUT_EN
                    hold_nxt  = '0;
`endif
                end
            end
            GRANT: begin
`ifdef HOLD_TIMEOUT_EN
                if (hold_cnt != {HOLD_W{1'b1}}) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
                release_c = bus.done || owner_drop_c || hold_lim_c;
`else
                release_c = bus.done || owner_drop_c;
`endif
                if (release_c) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    ptr_nxt   = gnt_idx + IDX_W'(1);
`ifdef HOLD_TIMEOUT_EN
                    // Pulse only when the hold limit alone forced the release.
                    timeout_nxt = hold_lim_c && !bus.done && !owner_drop_c;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    decoder_4_16 u_dec (
        .clk    (clk),
        .in     (gnt_idx),
        .enable (gnt_valid),
        .out    (onehot)
    );

    assign bus.gnt_valid  = gnt_valid;
    assign bus.gnt_idx    = gnt_idx;
    assign bus.gnt_onehot = onehot;
`ifdef HOLD_TIMEOUT_EN
    assign bus.timeout    = timeout;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Scoreboard bench for decoder_rr_scheduler: directed scenarios plus random traffic vs. a queue-level model.
module tb_decoder_rr_scheduler;

    localparam int unsigned MAX_HOLD = 8;
`ifdef HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        bit          v;
        int          idx;
        logic [15:0] oh;
        bit          to;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    decoder_rr_scheduler_if bus ();

    decoder_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;

    // Reference model: owner (-1 = nobody), rotating start pointer, cycles owned so far.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    bit   m_to    = 1'b0;

    task automatic model_step(input bit rst, input logic [15:0] r, input bit d);
        bit lim;
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 16; k++) begin
                int j;
                j = (m_ptr + k) % 16;
                if (r[j] === 1'b1) begin
                    m_owner = j;
                    m_held  = 1;
                    break;
                end
            end
        end else begin
            lim = TO_EN && (m_held == int'(MAX_HOLD));
            if (d || !r[m_owner] || lim) begin
                m_to    = lim && !d && r[m_owner];
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic drive(input bit rst, input logic [15:0] r, input bit d);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        bus.req  = r;
        bus.done = d;
        model_step(rst, r, d);
        ncyc++;
        e.v   = (m_owner >= 0);
        e.idx = e.v ? m_owner : 0;
        e.oh  = e.v ? (16'h0001 << m_owner) : 16'h0000;
        e.to  = m_to;
        e.cyc = ncyc;
        q.push_back(e);
    endtask

    task automatic check1(input string name, input int cyc, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: each posedge the DUT presents a new output sample; compare with the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check1("gnt_valid",  e.cyc, longint'(bus.gnt_valid),  longint'(e.v));
                check1("gnt_idx",    e.cyc, longint'(bus.gnt_idx),    longint'(e.idx));
                check1("gnt_onehot", e.cyc, longint'(bus.gnt_onehot), longint'(e.oh));
                check1("timeout",    e.cyc, longint'(bus.timeout),    longint'(e.to));
            end
        end
    end

    initial begin
        logic [15:0] r;
        reset    = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;

        // Reset held with every requester active.
        drive(1, 16'hFFFF, 0);
        drive(1, 16'hFFFF, 0);

        // Single requester 3, released by done.
        drive(0, 16'h0008, 0);
        drive(0, 16'h0008, 1);
        drive(0, 16'h0000, 0);

        // Fairness sweep from ptr=0 with done on every grant cycle.
        drive(1, 16'h0000, 0);
        for (int i = 0; i < 36; i++) drive(0, 16'hFFFF, m_owner >= 0);

        // Wrap: own 15, release, then 0, then contend 15 vs 0.
        drive(0, 16'h0000, 1);
        drive(0, 16'h8000, 0);
        drive(0, 16'h8000, 1);
        drive(0, 16'h0001, 0);
        drive(0, 16'h0001, 1);
        for (int i = 0; i < 4; i++) drive(0, 16'h8001, m_owner >= 0);

        // Hold limit: requester 5 never releases.
        drive(0, 16'h0000, 0);
        for (int i = 0; i < 24; i++) drive(0, 16'h0020, 0);

        // Owner drops its request mid-grant.
        drive(0, 16'h0000, 0);
        drive(0, 16'hFFFF, 0);
        drive(0, 16'hFFFF, 0);
        r = 16'hFFFF & ~(16'h0001 << ((m_owner < 0) ? 0 : m_owner));
        drive(0, r, 0);
        drive(0, 16'h0000, 0);

        // Reset during a grant, then full contention from ptr=0.
        drive(0, 16'h0400, 0);
        drive(0, 16'h0400, 0);
        drive(1, 16'h0400, 0);
        drive(0, 16'hFFFF, 0);
        drive(0, 16'hFFFF, 1);

        // Random traffic: sparse requests, occasional done and reset.
        for (int i = 0; i < 2000; i++) begin
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) r = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0 && m_owner >= 0) r = r | (16'h0001 << m_owner);
            drive($urandom_range(0, 149) == 0, r, $urandom_range(0, 5) == 0);
        end

        drive(0, 16'h0000, 1);
        repeat (3) @(negedge clk);
        check1("scoreboard_drained", ncyc, longint'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
